multdiv_unit: RTL
=================

Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the processor execute stage, beside the ALU.
- Accepts one-cycle start pulses from decode and computes over 32 iteration cycles.
- Result, exception and ready go to the writeback path, which drives data_writeReg/ctrl_writeEnable to the register file.
- The processor stalls while the unit is busy.

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement).
- CNT_W, 6, iteration counter width; must hold WIDTH+1.

Ports:
- clock  in  1  processor clock (all logic on posedge)
- ctrl_reset  in  1  asynchronous, active-low reset
- data_operandA  in  WIDTH  multiplicand / dividend; sampled only on a start edge
- data_operandB  in  WIDTH  multiplier / divisor; sampled only on a start edge
- ctrl_MULT  in  1  start-multiply pulse
- ctrl_DIV  in  1  start-divide pulse
- data_result  out  WIDTH  product low word / quotient
- data_exception  out  1  overflow or divide-by-zero flag for the last completed op
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  high while an operation is in flight

Behaviour:
- Reset (ctrl_reset=0, asynchronous):
  - state IDLE; all outputs 0; counter 0.
  - Applies immediately, including mid-operation; the aborted op never raises resultRDY.
- States:
  - IDLE
  - MULT: radix-2 Booth, one add/sub plus arithmetic shift per cycle.
  - DIV: non-restoring on operand magnitudes, one step per cycle.
  - DONE: single cycle.
- Start edge S is a posedge with exactly one of ctrl_MULT/ctrl_DIV high.
  - Accepted in any state. A start during MULT/DIV/DONE aborts the current op and restarts with the new operands; no resultRDY for the aborted op.
  - Both high at once: ignored; state unchanged.
  - Operands latched at S; input changes after S have no effect.
- Timing (uniform for every case, including divide-by-zero):
  - Iterations on edges S+1..S+32.
  - Enter DONE at S+33, return to IDLE at S+34.
  - data_resultRDY = 1 exactly from S+33 to S+34.
  - busy = 1 from S to S+33.
- data_result/data_exception:
  - Update only at S+33.
  - Held until the next completion or reset, so they are not cleared by a new start.
- Multiply:
  - data_result = low WIDTH bits of the signed 2·WIDTH product.
  - data_exception = 1 iff the upper WIDTH+1 product bits are not all equal, i.e. the product does not fit signed WIDTH.
- Divide:
  - Signed quotient, truncated toward zero; remainder discarded.
  - Quotient sign = signA XOR signB, applied at completion.
  - B = 0: result 0, exception 1.
  - A = −2^31 and B = −1: result 0x80000000, exception 1.
  - Otherwise exception 0.
- Datapath widths:
  - Multiply: 2·WIDTH+1 bit product/Booth register.
  - Divide: WIDTH+1 bit partial remainder.
  - Counter counts 0..WIDTH, cleared on every start.

Decomposition:
- Package multdiv_pkg holds:
  - state encoding (IDLE, MULT, DIV, DONE)
  - WIDTH/CNT_W defaults
  - MIN_INT constant 32'h80000000
- One sub-module, multdiv_counter: a synchronous-clear, enable-driven up-counter with terminal flag at WIDTH, async active-low reset. It is shared by both datapaths.
- Booth and non-restoring datapaths stay inline in multdiv_unit.

Test Plan:
- ctrl_MULT pulse, A=3, B=−7:
  - data_result=−21, exception=0.
  - resultRDY high exactly one cycle, 33 edges after the start edge.
  - busy low afterwards.
- ctrl_MULT, A=65536, B=65536 → result 0, exception 1. Then A=32767, B=65537 → result 2147450879, exception 0.
- Divide cases:
  - ctrl_DIV, A=−21, B=4 → result −5, exception 0.
  - A=2147483647, B=1 → 2147483647.
  - A=7, B=0 → result 0, exception 1, same 33-edge latency.
  - A=−2147483648, B=−1 → result −2147483648, exception 1.
- Abort on restart:
  - ctrl_MULT (A=5, B=6), then ctrl_DIV (A=100, B=7) at edge S+10.
  - No resultRDY at S+33.
  - Single resultRDY at S+43 with result 14.
- Reset and simultaneous starts:
  - ctrl_reset low at iteration 15 → all outputs 0 immediately, no resultRDY.
  - After release, ctrl_MULT and ctrl_DIV high together → unit stays IDLE, busy 0.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// default widths and the most-negative operand constant.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

endpackage

// File: rtl/multdiv_if.sv
// Decode/writeback side bundle of the multiply/divide unit.
// master = processor pipeline, slave = multdiv_unit.
interface multdiv_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );

endinterface

// File: rtl/multdiv_counter.sv
// Iteration counter shared by the Booth and non-restoring datapaths:
// synchronous clear, enable-driven increment, terminal flag at WIDTH.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == CNT_W'(WIDTH));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring on
// magnitudes) unit; 32 iteration cycles, one-cycle DONE with resultRDY.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic     clock,
  input  logic     ctrl_reset,
  multdiv_if.slave bus
);

  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN_INT);

  state_t r_state;
  state_t w_next;

  logic w_start_mult;
  logic w_start_div;
  logic w_start;
  logic w_busy;
  logic w_term;

  // Shared 2W+1 register: Booth {acc[W:0], multiplier[W-1:0]} or
  // divide {partial remainder[W:0], dividend/quotient[W-1:0]}.
  logic signed [2*WIDTH:0] r_prod;
  logic signed [WIDTH:0]   r_mcand;
  logic                    r_qm1;
  logic                    r_qneg;
  logic                    r_dz;
  logic                    r_ovf;
  logic [WIDTH-1:0]        r_result;
  logic                    r_exc;

  logic signed [WIDTH:0]   w_hi;
  logic signed [WIDTH:0]   w_msum;
  logic [2*WIDTH:0]        w_mult_next;
  logic signed [WIDTH:0]   w_dsh;
  logic signed [WIDTH:0]   w_dsum;
  logic [2*WIDTH:0]        w_div_next;

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic f_mul_ovf(input logic [WIDTH:0] hi);
    return !((&hi) || !(|hi));
  endfunction

  function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign w_start_mult = bus.ctrl_MULT & ~bus.ctrl_DIV;
  assign w_start_div  = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign w_start      = w_start_mult | w_start_div;
  assign w_busy       = (r_state == ST_MULT) || (r_state == ST_DIV);

  multdiv_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clock),
    .rst_n  (ctrl_reset),
    .i_clr  (w_start),
    .i_en   (w_busy & ~w_term),
    .o_term (w_term)
  );

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_start_mult) begin
      w_next = ST_MULT;
    end else if (w_start_div) begin
      w_next = ST_DIV;
    end else begin
      case (r_state)
        ST_MULT, ST_DIV: if (w_term) w_next = ST_DONE;
        ST_DONE:         w_next = ST_IDLE;
        default:         w_next = r_state;
      endcase
    end
  end

  // Booth step: add/sub multiplicand to the accumulator, then arithmetic shift.
  assign w_hi = r_prod[2*WIDTH:WIDTH];

  always_comb begin
    w_msum = w_hi;
    case ({r_prod[0], r_qm1})
      2'b01:   w_msum = w_hi + r_mcand;
      2'b10:   w_msum = w_hi - r_mcand;
      default: w_msum = w_hi;
    endcase
  end

  assign w_mult_next = {w_msum[WIDTH], w_msum, r_prod[WIDTH-1:1]};

  // Non-restoring step: sign of the remainder before the shift picks add/sub;
  // the top remainder bit is dropped because 2R always fits WIDTH+1 bits.
  assign w_dsh      = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_dsum     = r_prod[2*WIDTH] ? (w_dsh + r_mcand) : (w_dsh - r_mcand);
  assign w_div_next = {w_dsum, r_prod[WIDTH-2:0], ~w_dsum[WIDTH]};

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_prod   <= '0;
      r_mcand  <= '0;
      r_qm1    <= 1'b0;
      r_qneg   <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start_mult) begin
      r_prod  <= {{(WIDTH+1){1'b0}}, bus.data_operandB};
      r_mcand <= {bus.data_operandA[WIDTH-1], bus.data_operandA};
      r_qm1   <= 1'b0;
    end else if (w_start_div) begin
      r_prod  <= {{(WIDTH+1){1'b0}}, f_abs(bus.data_operandA)};
      r_mcand <= {1'b0, f_abs(bus.data_operandB)};
      r_qm1   <= 1'b0;
      r_qneg  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      r_dz    <= (bus.data_operandB == '0);
      r_ovf   <= (bus.data_operandA == L_MIN) && (bus.data_operandB == '1);
    end else if (w_busy && !w_term) begin
      r_prod <= (r_state == ST_MULT) ? w_mult_next : w_div_next;
      r_qm1  <= r_prod[0];
    end else if (w_busy && w_term) begin
      if (r_state == ST_MULT) begin
        r_result <= r_prod[WIDTH-1:0];
        r_exc    <= f_mul_ovf(r_prod[2*WIDTH-1:WIDTH-1]);
      end else if (r_dz) begin
        r_result <= '0;
        r_exc    <= 1'b1;
      end else if (r_ovf) begin
        r_result <= L_MIN;
        r_exc    <= 1'b1;
      end else begin
        r_result <= f_apply_sign(r_prod[WIDTH-1:0], r_qneg);
        r_exc    <= 1'b0;
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = (r_state == ST_DONE);
  assign bus.busy           = w_busy;

endmodule
